led_pattern_seq: RTL and testbench

- Parametrised successor of the fixed 4x8 LED pattern player: steps an address through a synchronous pattern ROM and drives NUM_BANKS output banks of BANK_W bits each.
- Adds a programmable step rate, four sequencing modes (loop up, loop down, ping-pong, one-shot), an enable/pause input and restart.
- Registered outputs with a step strobe.
- Sits between the board LED banks and an external single-port pattern ROM with 1-cycle read latency.

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_pattern_seq_if.sv | 28 ++
 rtl/led_tick_gen.sv | 40 ++++
 rtl/led_pattern_seq.sv | 139 +++++++++++++
 tb/tb_led_pattern_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_ONESHOT  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control, ROM and bank-output signals of the LED pattern sequencer.
interface led_pattern_seq_if #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BANK_W    = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned PRESC_W   = 24
);
    logic                          i_en;
    logic [1:0]                    i_mode;
    logic [PRESC_W-1:0]            i_rate;
    logic                          i_restart;
    logic [ADDR_W-1:0]             o_rom_addr;
    logic [NUM_BANKS*BANK_W-1:0]   i_rom_data;
    logic [NUM_BANKS*BANK_W-1:0]   o_banks;
    logic                          o_step;
    logic                          o_done;

    modport slave (
        input  i_en, i_mode, i_rate, i_restart, i_rom_data,
        output o_rom_addr, o_banks, o_step, o_done
    );

    modport master (
        output i_en, i_mode, i_rate, i_restart, i_rom_data,
        input  o_rom_addr, o_banks, o_step, o_done
    );

endinterface

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: one-cycle tick every (rate+1) enabled cycles.
module led_tick_gen #(
    parameter int unsigned PRESC_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_clear,
    input  logic [PRESC_W-1:0] i_rate,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;
    logic [PRESC_W-1:0] w_cnt_nxt;

    // >= rather than == so a rate lowered below the count ticks straight away
    always_comb begin
        o_tick    = 1'b0;
        w_cnt_nxt = r_cnt;
        if (i_clear) begin
            w_cnt_nxt = '0;
        end else if (i_en) begin
            if (r_cnt >= i_rate) begin
                o_tick    = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// Steps an address through an external 1-cycle-latency pattern ROM and
// drives registered LED banks with a step strobe on every update.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BANK_W    = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned PRESC_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pattern_seq_if.slave  bus
);

    localparam int unsigned        DATA_W = NUM_BANKS * BANK_W;
    localparam logic [ADDR_W-1:0]  LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]  ONE    = ADDR_W'(1);

    logic               w_tick;
    mode_e              w_mode;
    logic [ADDR_W-1:0]  w_start;

    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_issue;

    logic               r_issued;
    logic               r_fetched;
    logic [DATA_W-1:0]  r_banks;
    logic               r_step;

    led_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (bus.i_en),
        .i_clear (bus.i_restart),
        .i_rate  (bus.i_rate),
        .o_tick  (w_tick)
    );

    assign w_mode  = mode_e'(bus.i_mode);
    assign w_start = (w_mode == MODE_DOWN) ? LAST : '0;

    always_comb begin
        w_addr_nxt  = r_addr;
        w_dir_nxt   = r_dir;
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_issue     = 1'b0;
        if (bus.i_restart) begin
            w_addr_nxt  = w_start;
            w_dir_nxt   = DIR_UP;
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b0;
            w_issue     = 1'b1;
        end else if (w_tick && (r_state == ST_RUN)) begin
            w_issue = 1'b1;
            case (w_mode)
                MODE_UP:   w_addr_nxt = (r_addr >= LAST) ? '0 : r_addr + ONE;
                MODE_DOWN: w_addr_nxt = (r_addr == '0) ? LAST : r_addr - ONE;
                MODE_PINGPONG: begin
                    // endpoints are visited once; the turn-around skips straight inward
                    if (r_dir == DIR_UP) begin
                        if (r_addr >= LAST) begin
                            w_dir_nxt  = DIR_DOWN;
                            w_addr_nxt = LAST - ONE;
                        end else begin
                            w_addr_nxt = r_addr + ONE;
                        end
                    end else begin
                        if (r_addr == '0) begin
                            w_dir_nxt  = DIR_UP;
                            w_addr_nxt = ONE;
                        end else begin
                            w_addr_nxt = r_addr - ONE;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (r_addr >= LAST) begin
                        w_issue     = 1'b0;
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt = r_addr + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_dir   <= DIR_UP;
            r_state <= ST_RUN;
            r_done  <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_dir   <= w_dir_nxt;
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // r_issued resets high so address 0 is loaded once after reset, even when paused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued  <= 1'b1;
            r_fetched <= 1'b0;
            r_banks   <= '0;
            r_step    <= 1'b0;
        end else begin
            r_issued  <= w_issue;
            r_fetched <= r_issued;
            r_step    <= r_fetched;
            if (r_fetched) begin
                r_banks <= bus.i_rom_data;
            end
        end
    end

    assign bus.o_rom_addr = r_addr;
    assign bus.o_banks    = r_banks;
    assign bus.o_step     = r_step;
    assign bus.o_done     = r_done;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: three instances (DEPTH 128, 5, 4) on one clock.
module tb_led_pattern_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    led_pattern_seq_if #(.NUM_BANKS(4), .BANK_W(8), .ADDR_W(7), .PRESC_W(24)) b0 ();
    led_pattern_seq_if #(.NUM_BANKS(4), .BANK_W(8), .ADDR_W(7), .PRESC_W(24)) b5 ();
    led_pattern_seq_if #(.NUM_BANKS(4), .BANK_W(8), .ADDR_W(7), .PRESC_W(24)) b4 ();

    led_pattern_seq #(.NUM_BANKS(4), .BANK_W(8), .ADDR_W(7), .DEPTH(128), .PRESC_W(24)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );
    led_pattern_seq #(.NUM_BANKS(4), .BANK_W(8), .ADDR_W(7), .DEPTH(5), .PRESC_W(24)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );
    led_pattern_seq #(.NUM_BANKS(4), .BANK_W(8), .ADDR_W(7), .DEPTH(4), .PRESC_W(24)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM[i] = i replicated in every bank
    function automatic logic [31:0] rom(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {4{b}};
    endfunction

    always @(posedge clk) begin
        b0.i_rom_data <= rom(int'(b0.o_rom_addr));
        b5.i_rom_data <= rom(int'(b5.o_rom_addr));
        b4.i_rom_data <= rom(int'(b4.o_rom_addr));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        n_vec++;
        if (b0.o_banks !== 32'h0 || b0.o_step !== 1'b0 || b0.o_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got banks=%h step=%b done=%b want 0/0/0",
                     b0.o_banks, b0.o_step, b0.o_done);
        end
        n_vec++;
        if (b0.o_rom_addr !== 7'd0) begin
            n_err++;
            $display("FAIL reset_addr: got %0d want 0", b0.o_rom_addr);
        end
        rst_n = 1'b1;
        cyc(1);
        n_vec++;
        if (b0.o_banks !== 32'h0 || b0.o_step !== 1'b0) begin
            n_err++;
            $display("FAIL first_load_early: got banks=%h step=%b want 0/0", b0.o_banks, b0.o_step);
        end
        cyc(1);
        n_vec++;
        if (b0.o_banks !== rom(0) || b0.o_step !== 1'b1) begin
            n_err++;
            $display("FAIL first_load: got banks=%h step=%b want %h/1",
                     b0.o_banks, b0.o_step, rom(0));
        end
        cyc(1);
        n_vec++;
        if (b0.o_banks !== rom(0) || b0.o_step !== 1'b0) begin
            n_err++;
            $display("FAIL first_load_hold: got banks=%h step=%b want %h/0",
                     b0.o_banks, b0.o_step, rom(0));
        end
    endtask

    task automatic test_loop_up();
        logic [6:0]  ea;
        logic [31:0] eb;
        b0.i_mode = 2'b00;
        b0.i_rate = 24'd0;
        b0.i_en   = 1'b1;
        for (int k = 1; k <= 132; k++) begin
            cyc(1);
            ea = 7'(k % 128);
            n_vec++;
            if (b0.o_rom_addr !== ea) begin
                n_err++;
                $display("FAIL loop_addr k=%0d: got %0d want %0d", k, b0.o_rom_addr, ea);
            end
            if (k >= 3) begin
                eb = rom((k - 2) % 128);
                n_vec++;
                if (b0.o_banks !== eb || b0.o_step !== 1'b1) begin
                    n_err++;
                    $display("FAIL loop_banks k=%0d: got %h step=%b want %h step=1",
                             k, b0.o_banks, b0.o_step, eb);
                end
            end
        end
        b0.i_en = 1'b0;
        cyc(3);
    endtask

    task automatic test_rate_pause();
        logic        es;
        logic [31:0] eb;
        logic [6:0]  ea;
        b0.i_rate    = 24'd3;
        b0.i_restart = 1'b1;
        cyc(1);
        b0.i_restart = 1'b0;
        b0.i_en      = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            cyc(1);
            if (k >= 15 && k <= 24) begin
                es = 1'b0;
                eb = rom(3);
                ea = 7'd3;
            end else if (k >= 25) begin
                es = ((k - 12) % 4) == 0;
                eb = rom((k - 12) / 4);
                ea = 7'((k - 10) / 4);
            end else begin
                es = ((k - 2) % 4) == 0;
                eb = rom((k - 2) / 4);
                ea = 7'(k / 4);
            end
            if (k >= 2) begin
                n_vec++;
                if (b0.o_step !== es || b0.o_banks !== eb || b0.o_rom_addr !== ea) begin
                    n_err++;
                    $display("FAIL rate_step k=%0d: got step=%b banks=%h addr=%0d want %b/%h/%0d",
                             k, b0.o_step, b0.o_banks, b0.o_rom_addr, es, eb, ea);
                end
            end
            if (k == 14) b0.i_en = 1'b0;
            if (k == 24) b0.i_en = 1'b1;
        end
        b0.i_en = 1'b0;
        cyc(3);
    endtask

    task automatic test_pingpong();
        int seq[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
        b5.i_mode    = 2'b10;
        b5.i_rate    = 24'd0;
        b5.i_restart = 1'b1;
        cyc(1);
        b5.i_restart = 1'b0;
        b5.i_en      = 1'b1;
        for (int j = 0; j <= 9; j++) begin
            if (j > 0) cyc(1);
            n_vec++;
            if (b5.o_rom_addr !== 7'(seq[j])) begin
                n_err++;
                $display("FAIL pp_addr j=%0d: got %0d want %0d", j, b5.o_rom_addr, seq[j]);
            end
            if (j >= 2) begin
                n_vec++;
                if (b5.o_banks !== rom(seq[j-2])) begin
                    n_err++;
                    $display("FAIL pp_banks j=%0d: got %h want %h", j, b5.o_banks, rom(seq[j-2]));
                end
            end
        end
        b5.i_en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [31:0] eb;
        logic        ed;
        logic [6:0]  ea;
        b4.i_mode    = 2'b11;
        b4.i_rate    = 24'd1;
        b4.i_restart = 1'b1;
        cyc(1);
        b4.i_restart = 1'b0;
        b4.i_en      = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            cyc(1);
            eb = (j >= 8) ? rom(3) : rom((j - 2) / 2);
            ed = (j >= 8);
            ea = (j >= 6) ? 7'd3 : 7'(j / 2);
            if (j >= 2) begin
                n_vec++;
                if (b4.o_banks !== eb || b4.o_done !== ed || b4.o_rom_addr !== ea) begin
                    n_err++;
                    $display("FAIL oneshot j=%0d: got banks=%h done=%b addr=%0d want %h/%b/%0d",
                             j, b4.o_banks, b4.o_done, b4.o_rom_addr, eb, ed, ea);
                end
            end
            if (j >= 9) begin
                n_vec++;
                if (b4.o_step !== 1'b0) begin
                    n_err++;
                    $display("FAIL oneshot_nostep j=%0d: got step=%b want 0", j, b4.o_step);
                end
            end
            // mode change while finished must not move the address
            if (j == 10) b4.i_mode = 2'b01;
        end
        b4.i_mode    = 2'b11;
        b4.i_restart = 1'b1;
        cyc(1);
        b4.i_restart = 1'b0;
        n_vec++;
        if (b4.o_done !== 1'b0 || b4.o_rom_addr !== 7'd0) begin
            n_err++;
            $display("FAIL oneshot_restart: got done=%b addr=%0d want 0/0", b4.o_done, b4.o_rom_addr);
        end
        cyc(1);
        n_vec++;
        if (b4.o_banks !== rom(3)) begin
            n_err++;
            $display("FAIL oneshot_restart_early: got %h want %h", b4.o_banks, rom(3));
        end
        cyc(1);
        n_vec++;
        if (b4.o_banks !== rom(0) || b4.o_step !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_reload: got banks=%h step=%b want %h/1",
                     b4.o_banks, b4.o_step, rom(0));
        end
    endtask

    task automatic test_down_restart();
        b4.i_mode    = 2'b01;
        b4.i_rate    = 24'd0;
        b4.i_restart = 1'b1;
        cyc(1);
        b4.i_restart = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) cyc(1);
            n_vec++;
            if (b4.o_rom_addr !== 7'((3 - j) & 3)) begin
                n_err++;
                $display("FAIL down_addr j=%0d: got %0d want %0d", j, b4.o_rom_addr, (3 - j) & 3);
            end
            if (j >= 2) begin
                n_vec++;
                if (b4.o_banks !== rom((5 - j) & 3)) begin
                    n_err++;
                    $display("FAIL down_banks j=%0d: got %h want %h", j, b4.o_banks, rom((5 - j) & 3));
                end
            end
        end
        // a tick is due this cycle too; restart must win
        b4.i_restart = 1'b1;
        cyc(1);
        b4.i_restart = 1'b0;
        n_vec++;
        if (b4.o_rom_addr !== 7'd3) begin
            n_err++;
            $display("FAIL restart_vs_tick: got %0d want 3", b4.o_rom_addr);
        end
        cyc(1);
        n_vec++;
        if (b4.o_rom_addr !== 7'd2) begin
            n_err++;
            $display("FAIL restart_then_tick: got %0d want 2", b4.o_rom_addr);
        end
        b4.i_en = 1'b0;
        cyc(3);
    endtask

    task automatic test_async_reset();
        b0.i_mode    = 2'b00;
        b0.i_rate    = 24'd0;
        b0.i_en      = 1'b1;
        b4.i_mode    = 2'b11;
        b4.i_rate    = 24'd0;
        b4.i_en      = 1'b1;
        b4.i_restart = 1'b1;
        cyc(1);
        b4.i_restart = 1'b0;
        cyc(8);
        n_vec++;
        if (b4.o_done !== 1'b1 || b0.o_step !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got done=%b step=%b want 1/1", b4.o_done, b0.o_step);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (b0.o_banks !== 32'h0 || b0.o_step !== 1'b0 || b0.o_rom_addr !== 7'd0) begin
            n_err++;
            $display("FAIL async_reset: got banks=%h step=%b addr=%0d want 0/0/0",
                     b0.o_banks, b0.o_step, b0.o_rom_addr);
        end
        n_vec++;
        if (b4.o_done !== 1'b0 || b4.o_banks !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset_done: got done=%b banks=%h want 0/0", b4.o_done, b4.o_banks);
        end
        b0.i_en = 1'b0;
        b4.i_en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        n_vec++;
        if (b0.o_banks !== 32'h0 || b0.o_step !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_early: got banks=%h step=%b want 0/0", b0.o_banks, b0.o_step);
        end
        cyc(1);
        n_vec++;
        if (b0.o_banks !== rom(0) || b0.o_step !== 1'b1 || b4.o_banks !== rom(0)) begin
            n_err++;
            $display("FAIL post_reset_load: got banks=%h step=%b b4=%h want %h/1/%h",
                     b0.o_banks, b0.o_step, b4.o_banks, rom(0), rom(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        b0.i_en = 1'b0; b0.i_mode = 2'b00; b0.i_rate = '0; b0.i_restart = 1'b0;
        b5.i_en = 1'b0; b5.i_mode = 2'b00; b5.i_rate = '0; b5.i_restart = 1'b0;
        b4.i_en = 1'b0; b4.i_mode = 2'b00; b4.i_rate = '0; b4.i_restart = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_loop_up();
        test_rate_pause();
        test_pingpong();
        test_oneshot();
        test_down_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
